// File: rtl/fractal_renderer.sv
// Escape-time fractal renderer (Mandelbrot or Julia). Walks the viewport in raster order,
// runs one z iteration per clock and presents each pixel on a valid/ready plot port.
module fractal_renderer #(
    parameter int WIDTH     = 32,
    parameter int FRAC_BITS = 22,
    parameter int H_RES     = 320,
    parameter int V_RES     = 240,
    parameter int X_W       = 9,
    parameter int Y_W       = 8,
    parameter int ITER_W    = 16,
    parameter int COLOUR_W  = 3
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic                    start,
    input  logic                    mode,
    input  logic [ITER_W-1:0]       max_iter,
    input  logic signed [WIDTH-1:0] x_min,
    input  logic signed [WIDTH-1:0] y_min,
    input  logic signed [WIDTH-1:0] dx,
    input  logic signed [WIDTH-1:0] dy,
    input  logic signed [WIDTH-1:0] jc_re,
    input  logic signed [WIDTH-1:0] jc_im,
    input  logic                    plot_ready,
    output logic                    busy,
    output logic                    done,
    output logic [X_W-1:0]          vga_x,
    output logic [Y_W-1:0]          vga_y,
    output logic [COLOUR_W-1:0]     vga_colour,
    output logic                    vga_plot
);

    typedef enum logic [2:0] {
        S_IDLE = 3'd0,
        S_INIT = 3'd1,
        S_ITER = 3'd2,
        S_PLOT = 3'd3,
        S_DONE = 3'd4
    } state_t;

    localparam logic [X_W-1:0] LAST_X = X_W'(H_RES - 1);
    localparam logic [Y_W-1:0] LAST_Y = Y_W'(V_RES - 1);
    // 4.0 in fixed point, one bit wider than a word so the |z|^2 sum cannot wrap
    localparam logic signed [WIDTH:0] ESCAPE_LIMIT =
        {{(WIDTH-2){1'b0}}, 3'b100} << FRAC_BITS;

    state_t r_state;
    state_t w_state_next;

    // Frame parameters captured at start
    logic                    r_mode;
    logic [ITER_W-1:0]       r_max_iter;
    logic signed [WIDTH-1:0] r_x_min;
    logic signed [WIDTH-1:0] r_y_min;
    logic signed [WIDTH-1:0] r_dx;
    logic signed [WIDTH-1:0] r_dy;
    logic signed [WIDTH-1:0] r_jc_re;
    logic signed [WIDTH-1:0] r_jc_im;

    // Raster position and accumulated coordinates
    logic [X_W-1:0]          r_i;
    logic [Y_W-1:0]          r_j;
    logic signed [WIDTH-1:0] r_cx;
    logic signed [WIDTH-1:0] r_cy;

    // Iteration state
    logic signed [WIDTH-1:0] r_zr;
    logic signed [WIDTH-1:0] r_zi;
    logic signed [WIDTH-1:0] r_cr;
    logic signed [WIDTH-1:0] r_ci;
    logic [ITER_W-1:0]       r_n;

    logic signed [2*WIDTH-1:0] w_zr_ext;
    logic signed [2*WIDTH-1:0] w_zi_ext;
    logic signed [2*WIDTH-1:0] w_zr_sq_full;
    logic signed [2*WIDTH-1:0] w_zi_sq_full;
    logic signed [2*WIDTH-1:0] w_cross_full;
    logic signed [2*WIDTH-1:0] w_zr_sq_sh;
    logic signed [2*WIDTH-1:0] w_zi_sq_sh;
    logic signed [2*WIDTH-1:0] w_cross_sh;
    logic signed [WIDTH-1:0]   w_zr_sq;
    logic signed [WIDTH-1:0]   w_zi_sq;
    logic signed [WIDTH-1:0]   w_cross2;
    logic signed [WIDTH:0]     w_mag;
    logic signed [WIDTH-1:0]   w_zr_new;
    logic signed [WIDTH-1:0]   w_zi_new;
    logic                      w_escape;
    logic                      w_hit_max;
    logic                      w_iter_exit;
    logic                      w_transfer;
    logic                      w_last_x;
    logic                      w_last_pixel;

    // Full-precision products, rescaled and truncated back to a word
    assign w_zr_ext     = {{WIDTH{r_zr[WIDTH-1]}}, r_zr};
    assign w_zi_ext     = {{WIDTH{r_zi[WIDTH-1]}}, r_zi};
    assign w_zr_sq_full = w_zr_ext * w_zr_ext;
    assign w_zi_sq_full = w_zi_ext * w_zi_ext;
    assign w_cross_full = w_zr_ext * w_zi_ext;
    assign w_zr_sq_sh   = w_zr_sq_full >>> FRAC_BITS;
    assign w_zi_sq_sh   = w_zi_sq_full >>> FRAC_BITS;
    // Shifting by one bit less folds in the factor of two of 2*zr*zi
    assign w_cross_sh   = w_cross_full >>> (FRAC_BITS - 1);
    assign w_zr_sq      = w_zr_sq_sh[WIDTH-1:0];
    assign w_zi_sq      = w_zi_sq_sh[WIDTH-1:0];
    assign w_cross2     = w_cross_sh[WIDTH-1:0];

    assign w_mag       = {w_zr_sq[WIDTH-1], w_zr_sq} + {w_zi_sq[WIDTH-1], w_zi_sq};
    assign w_escape    = (w_mag > ESCAPE_LIMIT);
    assign w_hit_max   = (r_n == r_max_iter);
    assign w_iter_exit = w_escape || w_hit_max;
    assign w_zr_new    = w_zr_sq - w_zi_sq + r_cr;
    assign w_zi_new    = w_cross2 + r_ci;

    assign w_transfer   = (r_state == S_PLOT) && plot_ready;
    assign w_last_x     = (r_i == LAST_X);
    assign w_last_pixel = w_last_x && (r_j == LAST_Y);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (start) begin
                    w_state_next = S_INIT;
                end
            end
            S_INIT: begin
                w_state_next = S_ITER;
            end
            S_ITER: begin
                if (w_iter_exit) begin
                    w_state_next = S_PLOT;
                end
            end
            S_PLOT: begin
                if (plot_ready) begin
                    w_state_next = w_last_pixel ? S_DONE : S_INIT;
                end
            end
            S_DONE: begin
                // A held start must drop before another frame can begin
                if (!start) begin
                    w_state_next = S_IDLE;
                end
            end
            default: begin
                w_state_next = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_mode     <= 1'b0;
            r_max_iter <= '0;
            r_x_min    <= '0;
            r_y_min    <= '0;
            r_dx       <= '0;
            r_dy       <= '0;
            r_jc_re    <= '0;
            r_jc_im    <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_mode     <= mode;
            r_max_iter <= max_iter;
            r_x_min    <= x_min;
            r_y_min    <= y_min;
            r_dx       <= dx;
            r_dy       <= dy;
            r_jc_re    <= jc_re;
            r_jc_im    <= jc_im;
        end
    end

    // Coordinates are stepped by accumulation as the raster advances
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_i  <= '0;
            r_j  <= '0;
            r_cx <= '0;
            r_cy <= '0;
        end else if ((r_state == S_IDLE) && start) begin
            r_i  <= '0;
            r_j  <= '0;
            r_cx <= x_min;
            r_cy <= y_min;
        end else if (w_transfer && !w_last_pixel) begin
            if (w_last_x) begin
                r_i  <= '0;
                r_cx <= r_x_min;
                r_j  <= r_j + Y_W'(1);
                r_cy <= r_cy + r_dy;
            end else begin
                r_i  <= r_i + X_W'(1);
                r_cx <= r_cx + r_dx;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_zr <= '0;
            r_zi <= '0;
            r_cr <= '0;
            r_ci <= '0;
            r_n  <= '0;
        end else if (r_state == S_INIT) begin
            r_zr <= r_cx;
            r_zi <= r_cy;
            r_cr <= r_mode ? r_jc_re : r_cx;
            r_ci <= r_mode ? r_jc_im : r_cy;
            r_n  <= '0;
        end else if ((r_state == S_ITER) && !w_iter_exit) begin
            r_zr <= w_zr_new;
            r_zi <= w_zi_new;
            r_n  <= r_n + ITER_W'(1);
        end
    end

    // Outputs decode straight from state so reset clears them without a clock
    assign busy       = (r_state == S_INIT) || (r_state == S_ITER) || (r_state == S_PLOT);
    assign done       = (r_state == S_DONE);
    assign vga_plot   = (r_state == S_PLOT);
    assign vga_x      = vga_plot ? r_i : '0;
    assign vga_y      = vga_plot ? r_j : '0;
    assign vga_colour = (vga_plot && !w_hit_max) ? r_n[COLOUR_W-1:0] : '0;

endmodule

// File: tb/tb_fractal_renderer.sv
// Bench for fractal_renderer: a pixel-level escape-time model plus a per-cycle output checker,
// directed frames for the literal cases and randomized frames with random backpressure.
module tb_fractal_renderer;

    localparam int HR = 4;
    localparam int VR = 2;
    localparam int FB = 22;

    logic        clk = 1'b0;
    logic        rst = 1'b0;
    logic        start = 1'b0;
    logic        mode = 1'b0;
    logic [15:0] max_iter = '0;
    logic [31:0] x_min = '0, y_min = '0, dx = '0, dy = '0, jc_re = '0, jc_im = '0;
    logic        plot_ready = 1'b0;
    logic        busy, done, vga_plot;
    logic [8:0]  vga_x;
    logic [7:0]  vga_y;
    logic [2:0]  vga_colour;

    int n_cmp = 0;
    int n_fail = 0;

    fractal_renderer #(
        .WIDTH(32), .FRAC_BITS(FB), .H_RES(HR), .V_RES(VR),
        .X_W(9), .Y_W(8), .ITER_W(16), .COLOUR_W(3)
    ) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .max_iter(max_iter),
        .x_min(x_min), .y_min(y_min), .dx(dx), .dy(dy), .jc_re(jc_re), .jc_im(jc_im),
        .plot_ready(plot_ready), .busy(busy), .done(done), .vga_x(vga_x), .vga_y(vga_y),
        .vga_colour(vga_colour), .vga_plot(vga_plot)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input longint act, input longint exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic int fx_mul(input int a, input int b);
        return int'((longint'(a) * longint'(b)) >>> FB);
    endfunction

    // Escape-time count for one point, straight from the iteration rule
    function automatic int iter_model(input bit md, input int maxit, input int cx, input int cy,
                                      input int jr, input int ji);
        int zr, zi, cr, ci, sr, si, zi_new;
        longint mag;
        zr = cx; zi = cy;
        cr = md ? jr : cx;
        ci = md ? ji : cy;
        for (int n = 0; n <= maxit; n++) begin
            sr  = fx_mul(zr, zr);
            si  = fx_mul(zi, zi);
            mag = longint'(sr) + longint'(si);
            if (mag > (longint'(4) <<< FB) || n == maxit) return n;
            zi_new = int'((2 * longint'(zr) * longint'(zi)) >>> FB) + ci;
            zr = sr - si + cr;
            zi = zi_new;
        end
        return maxit;
    endfunction

    typedef struct {
        int x;
        int y;
        int colour;
        int k;
    } pix_t;

    pix_t m_q[$];
    int   m_phase = 0;   // 0 idle, 1 frame running, 2 frame finished
    int   m_neg = 0;
    int   m_rise = 0;

    function automatic void build_frame();
        pix_t p;
        int   maxit;
        maxit = int'(max_iter);
        m_q.delete();
        for (int j = 0; j < VR; j++) begin
            for (int i = 0; i < HR; i++) begin
                p.x = i;
                p.y = j;
                p.k = iter_model(mode, maxit, int'(x_min) + i * int'(dx),
                                 int'(y_min) + j * int'(dy), int'(jc_re), int'(jc_im));
                p.colour = (p.k == maxit) ? 0 : (p.k % 8);
                m_q.push_back(p);
            end
        end
    endfunction

    // Each pixel's plot appears k+2 cycles after its INIT; it then waits for plot_ready
    always @(negedge clk) begin
        bit plot_e;
        if (rst) begin
            m_phase = 0;
            m_q.delete();
        end else begin
            m_neg++;
            plot_e = (m_phase == 1) && (m_neg >= m_rise);
            check("busy", busy, m_phase == 1);
            check("done", done, m_phase == 2);
            check("vga_plot", vga_plot, plot_e);
            if (plot_e && vga_plot) begin
                check("vga_x", vga_x, m_q[0].x);
                check("vga_y", vga_y, m_q[0].y);
                check("vga_colour", vga_colour, m_q[0].colour);
            end
            case (m_phase)
                0: if (start) begin
                    build_frame();
                    m_phase = 1;
                    m_rise = m_neg + m_q[0].k + 3;
                end
                1: if (plot_e && plot_ready) begin
                    void'(m_q.pop_front());
                    if (m_q.size() == 0) m_phase = 2;
                    else m_rise = m_neg + m_q[0].k + 3;
                end
                default: if (!start) m_phase = 0;
            endcase
        end
    end

    task automatic begin_frame(input bit md, input int maxit, input int xm, input int ym,
                               input int ddx, input int ddy, input int jr, input int ji);
        @(posedge clk); #1;
        mode = md; max_iter = 16'(maxit);
        x_min = xm; y_min = ym; dx = ddx; dy = ddy; jc_re = jr; jc_im = ji;
        plot_ready = 1'b0;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    task automatic wait_plot();
        int cnt = 0;
        while (!vga_plot && cnt < 500) begin
            @(posedge clk); #1;
            cnt++;
        end
        if (!vga_plot) check("wait_plot_timeout", 0, 1);
    endtask

    // Holding start in DONE must not restart; dropping it returns to IDLE
    task automatic end_frame();
        start = 1'b1;
        plot_ready = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        check("done_held", done, 1);
        start = 1'b0;
        repeat (2) begin @(posedge clk); #1; end
        check("idle_after_done", done | busy, 0);
    endtask

    task automatic finish_frame(input int ready_pct);
        int cnt = 0;
        while (!done && cnt < 20000) begin
            @(posedge clk); #1;
            cnt++;
            if (done) break;
            plot_ready = ($urandom_range(0, 99) < ready_pct);
            start = 1'($urandom_range(0, 1));
            mode = 1'($urandom_range(0, 1));
            max_iter = 16'($urandom);
            x_min = $urandom; y_min = $urandom; dx = $urandom; dy = $urandom;
            jc_re = $urandom; jc_im = $urandom;
        end
        if (!done) check("frame_timeout", 0, 1);
        end_frame();
    endtask

    initial begin
        int cnt;
        int xs[$], ys[$], cs[$];
        logic [8:0] x0;
        logic [7:0] y0;
        logic [2:0] c0;

        // Asynchronous reset, observed before any clock edge
        #1 rst = 1'b1;
        #3;
        check("rst_busy", busy, 0);
        check("rst_done", done, 0);
        check("rst_plot", vga_plot, 0);
        check("rst_x", vga_x, 0);
        check("rst_y", vga_y, 0);
        check("rst_colour", vga_colour, 0);
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;

        // Hand-computed cases pin the model
        check("model_mandel_c1", iter_model(1'b0, 16, 1 << FB, 0, 0, 0), 2);
        check("model_julia_1p5", iter_model(1'b1, 16, 3 << (FB - 1), 0, 0, 0), 1);
        check("model_origin", iter_model(1'b0, 16, 0, 0, 0, 0), 16);
        check("model_maxit0", iter_model(1'b0, 0, 1 << 30, 0, 0, 0), 0);

        // Non-escape at c=0: plot rises 18 cycles after the start edge
        begin_frame(1'b0, 16, 0, 0, 0, 0, 0, 0);
        cnt = 0;
        while (!vga_plot && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
        end
        check("latency_maxit16", cnt, 18);
        check("colour_inside", vga_colour, 0);
        finish_frame(100);

        // Escape at n=2 for c=(1,0): |z|^2 == 4 must not escape
        begin_frame(1'b0, 16, 1 << FB, 0, 0, 0, 0, 0);
        wait_plot();
        check("colour_mandel_c1", vga_colour, 2);
        finish_frame(80);

        // Julia, jc=0, z0=(1.5,0)
        begin_frame(1'b1, 16, 3 << (FB - 1), 0, 0, 0, 0, 0);
        wait_plot();
        check("colour_julia", vga_colour, 1);
        finish_frame(80);

        // Raster order with max_iter=0 and an always-ready sink
        begin_frame(1'b0, 0, 1 << FB, 1 << FB, 1 << 20, 1 << 20, 0, 0);
        plot_ready = 1'b1;
        cnt = 0;
        while (!done && cnt < 200) begin
            @(posedge clk); #1;
            cnt++;
            if (vga_plot) begin
                xs.push_back(int'(vga_x));
                ys.push_back(int'(vga_y));
                cs.push_back(int'(vga_colour));
            end
        end
        check("raster_count", xs.size(), HR * VR);
        for (int p = 0; p < xs.size() && p < HR * VR; p++) begin
            check("raster_x", xs[p], p % HR);
            check("raster_y", ys[p], p / HR);
            check("raster_colour", cs[p], 0);
        end
        check("raster_done", done, 1);
        check("raster_busy", busy, 0);
        end_frame();

        // Backpressure: outputs hold while plot_ready is low
        begin_frame(1'b1, 3, 1 << 20, 1 << 20, 1 << 21, 1 << 21, 1 << 21, 1 << 20);
        wait_plot();
        x0 = vga_x; y0 = vga_y; c0 = vga_colour;
        check("bp_first_x", x0, 0);
        check("bp_first_y", y0, 0);
        for (int c = 0; c < 5; c++) begin
            @(posedge clk); #1;
            check("bp_plot_hold", vga_plot, 1);
            check("bp_x_hold", vga_x, x0);
            check("bp_y_hold", vga_y, y0);
            check("bp_colour_hold", vga_colour, c0);
        end
        plot_ready = 1'b1;
        @(posedge clk); #1;
        plot_ready = 1'b0;
        check("bp_plot_drop", vga_plot, 0);
        wait_plot();
        check("bp_next_x", vga_x, 1);
        check("bp_next_y", vga_y, 0);
        finish_frame(50);

        // Randomized frames
        for (int f = 0; f < 6; f++) begin
            begin_frame(1'($urandom_range(0, 1)), int'($urandom_range(0, 24)),
                        int'($urandom_range(0, 3 << FB)) - (2 << FB),
                        int'($urandom_range(0, 3 << FB)) - (3 << (FB - 1)),
                        int'($urandom_range(0, 1 << (FB - 1))) - (1 << (FB - 2)),
                        int'($urandom_range(0, 1 << (FB - 1))) - (1 << (FB - 2)),
                        int'($urandom_range(0, 2 << FB)) - (1 << FB),
                        int'($urandom_range(0, 2 << FB)) - (1 << FB));
            finish_frame(60);
        end

        // Mid-frame reset during PLOT
        begin_frame(1'b0, 5, 0, 0, 1 << 20, 1 << 20, 0, 0);
        wait_plot();
        #1 rst = 1'b1;
        #1;
        check("midrst_plot", vga_plot, 0);
        check("midrst_busy", busy, 0);
        check("midrst_done", done, 0);
        check("midrst_x", vga_x, 0);
        check("midrst_y", vga_y, 0);
        check("midrst_colour", vga_colour, 0);
        @(posedge clk); #1;
        rst = 1'b0;
        plot_ready = 1'b1;
        repeat (30) begin @(posedge clk); #1; end
        check("midrst_no_plot", vga_plot | busy, 0);

        // Start present on the first edge after reset release is accepted
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        mode = 1'b1; max_iter = 16'd7;
        x_min = -(1 << FB); y_min = 1 << (FB - 1); dx = 1 << (FB - 1); dy = -(1 << (FB - 1));
        jc_re = -(1 << (FB - 1)); jc_im = 1 << (FB - 2);
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        check("start_after_rst", busy, 1);
        finish_frame(70);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/fractal_renderer.md
FRACTAL_RENDERER -- requirements
Module: fractal_renderer

Interface
REQ-001 Parameters SHALL be as follows:
- WIDTH, default 32: signed fixed-point word width.
- FRAC_BITS, default 22: number of fraction bits.
- H_RES, default 320: pixels per row.
- V_RES, default 240: rows per frame.
- X_W, default 9: width of vga_x.
- Y_W, default 8: width of vga_y.
- ITER_W, default 16: width of the iteration counter.
- COLOUR_W, default 3: width of vga_colour.

REQ-002 Ports SHALL be as follows. Design has one clock; reset is asynchronous and active-high.
- clk, in, 1: sole clock, rising edge.
- rst, in, 1: asynchronous active-high reset.
- start, in, 1: begin a frame.
- mode, in, 1: 0 = Mandelbrot, 1 = Julia.
- max_iter, in, ITER_W: iteration limit.
- x_min, in, WIDTH: left edge of viewport, signed.
- y_min, in, WIDTH: top edge of viewport, signed.
- dx, in, WIDTH: per-pixel x step, signed.
- dy, in, WIDTH: per-row y step, signed.
- jc_re, in, WIDTH: Julia constant, real part, signed.
- jc_im, in, WIDTH: Julia constant, imaginary part, signed.
- plot_ready, in, 1: sink accepts the pixel.
- busy, out, 1: frame in progress.
- done, out, 1: frame complete.
- vga_x, out, X_W: pixel column.
- vga_y, out, Y_W: pixel row.
- vga_colour, out, COLOUR_W: pixel colour.
- vga_plot, out, 1: pixel valid.

Function
REQ-003 The FSM SHALL have states IDLE, INIT, ITER, PLOT and DONE.

REQ-004 In IDLE, start=1 SHALL latch mode, max_iter, x_min, y_min, dx, dy, jc_re and jc_im, clear i and j, and go to INIT. Later input changes SHALL NOT affect the frame in progress.

REQ-005 Pixel coordinates SHALL be formed by accumulation, not multiplication:
- cx = x_min + i*dx, reloaded to x_min when i returns to 0.
- cy = y_min + j*dy.

REQ-006 INIT SHALL last one cycle and then go to ITER, with n=0 and the following loaded:
- Mandelbrot: z=(cx,cy), c=(cx,cy).
- Julia: z=(cx,cy), c=(jc_re,jc_im).

REQ-007 Fixed-point products SHALL be formed at full 2*WIDTH signed precision, arithmetic-shifted right by FRAC_BITS, then truncated to WIDTH. No saturation is applied; wrap is accepted.

REQ-008 In each ITER cycle, evaluated on the current z:
- if |z|^2 = zr*zr + zi*zi > 4.0 (strict, fixed-point 4<<FRAC_BITS), or n == max_iter, go to PLOT;
- otherwise zr <= zr*zr - zi*zi + cr, zi <= 2*zr*zi + ci, n <= n+1, and stay in ITER.
- Exactly one iteration is performed per clock.

REQ-009 vga_colour SHALL be 0 when n == max_iter (inside the set); otherwise it SHALL be n[COLOUR_W-1:0].

REQ-010 max_iter = 0 SHALL give exactly one ITER cycle and colour 0.

REQ-011 Latency: for a pixel leaving ITER with count k, vga_plot SHALL rise k+2 cycles after the cycle in which INIT is entered, for the first pixel counted from the start-sampling edge.

REQ-012 In PLOT:
- vga_plot=1, vga_x=i, vga_y=j.
- vga_plot, vga_x, vga_y and vga_colour SHALL hold stable until plot_ready=1 is sampled.
- Transfer occurs on the edge where vga_plot and plot_ready are both 1.
- vga_plot SHALL be 0 in every other state.

REQ-013 After a transfer:
- if i < H_RES-1: i++, cx += dx, go to INIT;
- else: i=0, cx=x_min, j++, cy += dy, go to INIT;
- if i = H_RES-1 and j = V_RES-1: go to DONE, with no j increment.

REQ-014 Pixel order SHALL be raster, x inner; each (i,j) SHALL be plotted exactly once per frame.

REQ-015 busy SHALL be 1 in INIT, ITER and PLOT. done SHALL be 1 only in DONE.

REQ-016 DONE SHALL hold until start=0 is sampled, then go to IDLE. start=1 in DONE SHALL NOT restart a frame; the restart requires a start-low, then start-high sequence.

REQ-017 start SHALL be ignored while busy=1.

REQ-018 plot_ready SHALL be ignored outside PLOT.

Reset
REQ-019 rst=1 SHALL asynchronously force IDLE and clear i, j, n, z, c and all latched registers to 0. All outputs SHALL go to 0 without waiting for a clock edge.

REQ-020 Reset asserted mid-frame SHALL abandon the frame; no further vga_plot is issued until a new start after reset deassertion.

REQ-021 A start present on the first edge after rst deasserts SHALL be accepted.

Verification
REQ-022 Mid-frame reset: pulse rst during PLOT -> all outputs 0 before the next clk edge, FSM in IDLE, no plot until the next start.

REQ-023 Raster order: H_RES=4, V_RES=2, max_iter=0, plot_ready=1 -> 8 plots in order (0,0),(1,0),(2,0),(3,0),(0,1)..(3,1), all colour 0, then done=1 with busy=0.

REQ-024 Mandelbrot non-escape: mode=0, one pixel at c=(0,0), max_iter=16 -> colour 0, vga_plot rises 18 cycles after start is sampled.

REQ-025 Mandelbrot escape: mode=0, c=(1.0,0) -> |z|^2 sequence 1, 4, 25, escape at n=2, colour 2. This checks that |z|^2 = 4.0 does not escape.

REQ-026 Julia escape: mode=1, jc=(0,0), z0=(1.5,0) -> |z|^2 = 2.25 then 5.0625, colour 1.

REQ-027 Backpressure: hold plot_ready=0 for 5 cycles during PLOT -> vga_plot, vga_x, vga_y and vga_colour stable for all 5 cycles, i/j advance only on the first edge where plot_ready=1.
